adder_seq: RTL and testbench

Multi-cycle add/subtract sequencer that computes a WIDTH-bit result by iterating a 4-bit nibble adder slice, least-significant nibble first, one nibble per clock.
- Flag semantics match the team's 4-bit ALU adder: Sub=1 means a + ~b + 1; Carry is the raw carry-out (1 = no borrow on subtract); Overflow is the signed overflow; Zero means the result is all zero.
- Sits between an ALU front end and wide datapath consumers.
- Uses valid/ready handshakes on both sides.

---
 rtl/adder_seq.sv | 122 ++++++++++++
 tb/tb_adder_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// adder_seq: WIDTH-bit add/subtract computed one 4-bit nibble per clock, LSB nibble first.
// Build option: define ADDER_SEQ_SAT_EN to saturate Result on signed overflow.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one nibble per clock, NIBBLES cycles
// DONE  | result presented, waiting for out_ready
module adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, bx_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_nib;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] res_nxt, res_fin;
  logic             ovf_nxt;

  assign last_nib = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Nibble slice; the full next result is needed so Zero can see the final nibble.
  always_comb begin
    nib_sum = {1'b0, a_q[4*cnt +: 4]} + {1'b0, bx_q[4*cnt +: 4]} + {4'b0, carry_q};
    res_nxt = Result;
    res_nxt[4*cnt +: 4] = nib_sum[3:0];
    ovf_nxt = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
    res_fin = res_nxt;
`ifdef ADDER_SEQ_SAT_EN
    if (ovf_nxt)
      res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      bx_q     <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      Result   <= '0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            bx_q    <= in_b ^ {WIDTH{Sub}};
            carry_q <= Sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          carry_q <= nib_sum[4];
          cnt     <= cnt + 1'b1;
          if (last_nib) begin
            Result   <= res_fin;
            Carry    <= nib_sum[4];
            Overflow <= ovf_nxt;
            Zero     <= (res_fin == '0);
          end else begin
            Result <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq (WIDTH=16): stimulus pushes expected results, a monitor pops on out_valid.
module tb_adder_seq;
  localparam int W = 16;
  localparam int NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         Sub;
  logic         out_valid, out_ready;
  logic [W-1:0] Result;
  logic         Carry, Zero, Overflow, busy;

  int   compares = 0;
  int   errors   = 0;
  exp_t sb_q[$];

  adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Carry(Carry), .Zero(Zero), .Overflow(Overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    longint ua, ub, sa, sb, ur, sr, modw;
    exp_t   e;
    modw = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - modw : ua;
    sb = b[W-1] ? ub - modw : ub;
    if (sub) begin
      ur  = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur  = ua + ub;
      sr  = sa + sb;
      e.c = (ur >= modw);
    end
    e.r = ur[W-1:0];
    e.v = (sr > (modw / 2 - 1)) || (sr < -(modw / 2));
`ifdef ADDER_SEQ_SAT_EN
    if (e.v) e.r = (sa < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready;
    if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
    bit ok;
    int n;
    wait_ready(ok);
    if (!ok) return;
    in_a = a; in_b = b; Sub = sub; in_valid = 1'b1;
    sb_q.push_back(model(a, b, sub));
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); Sub = 1'($urandom);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(NIB));
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom); Sub = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: first DONE cycle pops the expectation, later DONE cycles check it is held.
  initial begin : monitor
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else if (out_valid) begin
        if (!have) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            cur  = sb_q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          chk("result", 32'(Result), 32'(cur.r));
          chk("carry", 32'(Carry), 32'(cur.c));
          chk("zero", 32'(Zero), 32'(cur.z));
          chk("overflow", 32'(Overflow), 32'(cur.v));
          chk("done_in_ready", 32'(in_ready), 32'd0);
          chk("done_busy", 32'(busy), 32'd1);
        end
        if (out_ready) have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; Sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_flags", {29'd0, Carry, Zero, Overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h0005, 16'h0005, 1'b1, 1);
    do_op(16'h0000, 16'h0001, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'hA5A5, 16'h5A5A, 1'b0, 10);

    // Abort after two RUN cycles; nothing is pushed, so any later output would be flagged.
    wait_ready(ok);
    in_a = 16'hFFFF; in_b = 16'h0001; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(Result), 32'd0);
    chk("abort_flags", {29'd0, Carry, Zero, Overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0001, 16'h0001, 1'b0, 0);

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b1, 2);
    do_op(16'h0000, 16'h8000, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 0);
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
